input_frame_loader: RTL

INPUT_FRAME_LOADER -- requirements
Module: input_frame_loader

---
 rtl/input_frame_loader_pkg.sv | 25 ++
 rtl/input_frame_loader_pix.sv | 31 +++
 rtl/input_frame_loader.sv | 138 +++++++++++++
 3 files changed

// File: rtl/input_frame_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : input_frame_loader_pkg
// Description : Shared state encoding and default frame/word constants.
// Revision    : 1.0
// ============================================================================
package input_frame_loader_pkg;

    // Defaults shared with neural_net so both ends agree on the frame layout.
    localparam int C_N_PIX     = 784;
    localparam int C_DATA_W    = 16;
    localparam int C_FRAC_BITS = 11;
    localparam int C_PIX_W     = 8;
    localparam int C_TIMEOUT   = 4096;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_START = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/input_frame_loader_pix.sv
`default_nettype none
// ============================================================================
// Module      : pix_to_fixed
// Description : Zero-extends a raw pixel and aligns it to the fixed-point grid.
// Revision    : 1.0
// ============================================================================
module pix_to_fixed #(
    parameter int PIX_W     = 8,
    parameter int DATA_W    = 16,
    parameter int FRAC_BITS = 11
) (
    input  logic [PIX_W-1:0]  pix,
    output logic [DATA_W-1:0] fixed
);

    localparam int SHIFT = FRAC_BITS - PIX_W;

    logic [DATA_W-1:0] w_ext;
    assign w_ext = DATA_W'(pix);

    // Pure shift: bits pushed past the top are dropped, nothing is rounded.
    generate
        if (SHIFT >= 0) begin : g_shl
            assign fixed = w_ext << SHIFT;
        end else begin : g_shr
            assign fixed = w_ext >> (-SHIFT);
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/input_frame_loader.sv
`default_nettype none
// ============================================================================
// Module      : input_frame_loader
// Description : Streams pixels into a frame buffer, starts the network and
//               captures its class result under a watchdog.
// Revision    : 1.0
// ============================================================================
module input_frame_loader
    import input_frame_loader_pkg::*;
#(
    parameter int N_PIX     = C_N_PIX,
    parameter int DATA_W    = C_DATA_W,
    parameter int FRAC_BITS = C_FRAC_BITS,
    parameter int PIX_W     = C_PIX_W,
    parameter int TIMEOUT   = C_TIMEOUT
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    pix_valid,
    input  logic [PIX_W-1:0]        pix_data,
    output logic                    pix_ready,
    output logic [N_PIX*DATA_W-1:0] frame,
    output logic                    first,
    input  logic                    net_done,
    input  logic [3:0]              net_result,
    output logic [3:0]              result,
    output logic                    result_valid,
    output logic                    timeout_err,
    output logic [15:0]             frame_cnt
);

    localparam int IDX_W = (N_PIX > 1) ? $clog2(N_PIX) : 1;
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(N_PIX - 1);
    localparam logic [CNT_W-1:0] C_LAST_CNT = CNT_W'(TIMEOUT - 1);

    state_t              r_state;
    state_t              w_next_state;
    logic [IDX_W-1:0]    r_idx;
    logic [CNT_W-1:0]    r_wait_cnt;
    logic [N_PIX*DATA_W-1:0] r_frame;
    logic [DATA_W-1:0]   w_fixed;
    logic                w_accept;
    logic                w_capture;
    logic                w_timeout_hit;
    logic                w_last_pix;

    pix_to_fixed #(
        .PIX_W     (PIX_W),
        .DATA_W    (DATA_W),
        .FRAC_BITS (FRAC_BITS)
    ) u_pix_to_fixed (
        .pix   (pix_data),
        .fixed (w_fixed)
    );

    assign w_last_pix = (r_idx == C_LAST_IDX);
    assign frame      = r_frame;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state  = r_state;
        pix_ready     = 1'b0;
        first         = 1'b0;
        result_valid  = 1'b0;
        w_accept      = 1'b0;
        w_capture     = 1'b0;
        w_timeout_hit = 1'b0;
        case (r_state)
            ST_IDLE, ST_LOAD: begin
                pix_ready = 1'b1;
                w_accept  = pix_valid;
                if (pix_valid) begin
                    w_next_state = w_last_pix ? ST_START : ST_LOAD;
                end
            end
            ST_START: begin
                first        = 1'b1;
                w_next_state = ST_WAIT;
            end
            ST_WAIT: begin
                // A result on the final watchdog cycle still wins.
                if (net_done) begin
                    w_capture    = 1'b1;
                    w_next_state = ST_DONE;
                end else if (r_wait_cnt == C_LAST_CNT) begin
                    w_timeout_hit = 1'b1;
                    w_next_state  = ST_IDLE;
                end
            end
            ST_DONE: begin
                result_valid = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame     <= '0;
            r_idx       <= '0;
            r_wait_cnt  <= '0;
            result      <= 4'd0;
            timeout_err <= 1'b0;
            frame_cnt   <= 16'd0;
        end else begin
            // Buffer is rewritten in place; untouched words keep the old frame.
            if (w_accept) begin
                r_frame[r_idx*DATA_W +: DATA_W] <= w_fixed;
                r_idx <= w_last_pix ? '0 : r_idx + 1'b1;
            end
            if (r_state == ST_WAIT) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end else begin
                r_wait_cnt <= '0;
            end
            if (w_capture) begin
                result <= net_result;
            end
            if (w_timeout_hit) begin
                timeout_err <= 1'b1;
            end
            if (r_state == ST_DONE) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

endmodule
`default_nettype wire
